// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared constants and state type for the fetch stage
package instruction_fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small flushable FIFO buffering {pc, instr} pairs for decode
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage with credit-limited imem requests, redirect flush and decode FIFO
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  fetch_state_e state, state_nxt;
  logic [XLEN-1:0] pc, resp_pc, target;
  logic [CW-1:0] outstanding, inflight_nxt, drop_cnt, drop_cnt_nxt, fifo_count;
  logic accept, resp, push, pop, empty;
  logic [XLEN+31:0] head;
  assign target = redirect_pc & ~XLEN'(3);
  // a response with nothing outstanding is a leftover from before reset and is ignored
  assign resp = imem_resp_valid && outstanding != '0;
  assign imem_req_valid = state != IDLE && {1'b0, outstanding} + {1'b0, fifo_count} < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign inflight_nxt = outstanding + CW'(accept) - CW'(resp);
  assign push = resp && drop_cnt == '0 && !redirect_valid;
  assign pop = if_valid && if_ready;
  assign if_valid = !empty;
  assign {if_pc, if_instr} = empty ? {XLEN'(0), NOP_INSTR} : head;
  always_comb begin
    drop_cnt_nxt = redirect_valid ? inflight_nxt : (resp && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
    state_nxt = state == IDLE ? RUN
              : redirect_valid ? ((state == DRAIN || inflight_nxt != '0) ? DRAIN : RUN)
              : (state == DRAIN && drop_cnt_nxt == '0) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      outstanding <= inflight_nxt;
      drop_cnt <= drop_cnt_nxt;
      pc <= redirect_valid ? target : accept ? pc + XLEN'(4) : pc;
      resp_pc <= redirect_valid ? target : push ? resp_pc + XLEN'(4) : resp_pc;
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN + 32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({resp_pc, imem_resp_data}),
    .dout  (head),
    .empty (empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: in-order memory model plus a PC-stream reference checked against fetch outputs
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst_n = 0;
  logic imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0, redirect_valid = 0;
  logic if_valid, if_ready = 0;
  logic [31:0] imem_req_addr, imem_resp_data = 0, redirect_pc = 0, if_pc, if_instr;
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t mq[$];
  int checks = 0, errors = 0, cyc = 0, lat = 1, first_valid = -1, pops = 0;
  bit auto_redir = 0, hit = 0;
  logic [31:0] exp_req = 0, exp_pop = 0, auto_tgt = 0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check the fetched streams, then advance the model past the edge
  task automatic step(input bit rdy, input bit ifr, input bit redir, input logic [31:0] tgt);
    bit rv, acc, pop, rd;
    logic [31:0] t;
    @(negedge clk);
    rv = mq.size() > 0 && mq[0].due <= cyc;
    rd = redir;
    t = tgt;
    if (auto_redir && rv && imem_req_valid && rdy) begin
      rd = 1;
      t = auto_tgt;
      auto_redir = 0;
      hit = 1;
    end
    imem_req_ready = rdy;
    if_ready = ifr;
    redirect_valid = rd;
    redirect_pc = t;
    imem_resp_valid = rv;
    imem_resp_data = rv ? word(mq[0].addr) : $urandom;
    #1;
    acc = imem_req_valid && rdy;
    pop = if_valid && ifr;
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
    if (pop) begin
      chk("if_pc", if_pc, exp_pop);
      chk("if_instr", if_instr, word(exp_pop));
      exp_pop += 4;
      pops++;
    end
    if (if_valid && first_valid < 0) first_valid = cyc;
    if (rv) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      exp_req += 4;
    end
    if (rd) begin
      exp_req = t & ~32'h3;
      exp_pop = exp_req;
    end
    chk("credit", 32'(mq.size() <= 2), 32'd1);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    redirect_valid = 0;
    imem_resp_valid = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, NOP);
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    imem_resp_valid = 1;
    imem_resp_data = 32'hDEADBEEF;
    cyc = 0;
    first_valid = -1;
    exp_req = 0;
    exp_pop = 0;
  endtask

  initial begin
    // basic streaming with a 1-cycle memory
    lat = 1;
    do_reset();
    repeat (20) step(1, 1, 0, 0);
    chk("first_valid_cycle", 32'(first_valid), 32'd2);
    chk("t1_pops", 32'(pops > 8), 32'd1);
    // decode stall: buffer fills, requests stop, nothing lost afterwards
    repeat (10) step(1, 0, 0, 0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inflight", 32'(mq.size()), 32'd0);
    chk("stall_if_valid", 32'(if_valid), 32'd1);
    repeat (10) step(1, 1, 0, 0);
    // redirect with two responses in flight
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && mq.size() < 2; i++) step(1, 1, 0, 0);
    chk("t3_inflight", 32'(mq.size()), 32'd2);
    pops = 0;
    step(1, 1, 1, 32'h100);
    repeat (15) step(1, 1, 0, 0);
    chk("t3_pops", 32'(pops > 0), 32'd1);
    // redirect coinciding with a response and a request accept
    lat = 1;
    do_reset();
    hit = 0;
    auto_tgt = 32'h200;
    auto_redir = 1;
    for (int i = 0; i < 20 && !hit; i++) step(1, 1, 0, 0);
    auto_redir = 0;
    chk("t4_hit", 32'(hit), 32'd1);
    repeat (10) step(1, 1, 0, 0);
    // unaligned redirect target and PC wrap
    step(1, 1, 1, 32'h0000_0102);
    step(1, 1, 0, 0);
    chk("t5_aligned_addr", imem_req_addr, 32'h100);
    repeat (6) step(1, 1, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFFC);
    repeat (12) step(1, 1, 0, 0);
    // reset in the middle of a drain
    lat = 3;
    for (int i = 0; i < 10 && mq.size() == 0; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h300);
    lat = 1;
    do_reset();
    repeat (15) step(1, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
